sparce_sasa_loader: RTL and testbench
=====================================

# sparce_sasa_loader

Write-sequencing controller for the SparCE SASA table. It sits between the CSR-side configuration path and the SASA table. It buffers software write requests in a small queue and quiesces the table by deasserting `sasa_enable` and waiting out any in-flight skip. It then drains the buffered writes into the table one per cycle and re-enables lookups after a settle window, so the PSRU never acts on a partially programmed entry.

## Interface
- `QUEUE_DEPTH`, 4: write-request queue entries; power of two, at least 2.
- `SETTLE_CYCLES`, 2: cycles `sasa_enable` stays low after the last table write; at least 1.
- `CLK` in 1: clock; all state updates on the rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `req_valid` in 1: CSR-side write request valid.
- `req_ready` out 1: queue can accept; equals not-full.
- `req_addr` in 32: SASA table address for the request.
- `req_data` in 32: SASA table write data.
- `enable_req` in 1: software-requested SASA enable level.
- `skipping` in 1: PSRU skip in progress.
- `sasa_wen` out 1: table write strobe; registered.
- `sasa_addr` out 32: table write address; registered.
- `sasa_data` out 32: table write data; registered.
- `sasa_enable` out 1: table lookup enable; registered.
- `busy` out 1: high in every state except IDLE.

## Operation
- Queue: circular buffer with `$clog2(QUEUE_DEPTH)+1`-bit read/write pointers; full and empty are derived from the MSB compare.
  - Push on `req_valid && req_ready`.
  - `req_ready` is `!full` and does not depend on pop, so there is no push while full even in a pop cycle.
  - Push and pop in the same cycle are allowed when not full.
- FSM, four states: IDLE, QUIESCE, DRAIN, SETTLE.
  - IDLE: `sasa_enable` follows `enable_req`, registered. If the queue is not empty, go to QUIESCE and clear `sasa_enable` on the same edge.
  - QUIESCE: `sasa_enable` is 0. When `skipping == 0`, go to DRAIN; otherwise hold.
  - DRAIN: each cycle with the queue not empty and `skipping == 0`, pop the head. `sasa_wen`, `sasa_addr` and `sasa_data` register to 1 and the head entry. Otherwise `sasa_wen` registers to 0 and the address/data outputs hold their values. When the queue is empty, go to SETTLE and load the settle counter with `SETTLE_CYCLES-1`.
  - SETTLE: decrement the counter each cycle. If the queue becomes non-empty, return to DRAIN with `sasa_enable` still 0. When the counter reaches 0 with the queue empty, go to IDLE; `sasa_enable` then takes `enable_req` on the following edge.
- `skipping` asserting during DRAIN, which is abnormal, stalls pops and does not drop them.
- Changes to `enable_req` outside IDLE are ignored until the block returns to IDLE.
- Reset, including mid-DRAIN:
  - Queue pointers go to 0 and queued writes are discarded.
  - State goes to IDLE and the settle counter to 0.
  - `sasa_wen`, `sasa_enable` and `busy` go to 0; `sasa_addr` and `sasa_data` go to 0.
  - `req_ready` is 1 after reset.

## Timing
- Push sampled at edge E0 into an empty queue, in IDLE, with `skipping = 0`:
  - E1: QUIESCE, `sasa_enable` = 0.
  - E2: DRAIN.
  - E3: pop; `sasa_wen` = 1 during the cycle after E3.
  - Push-to-write latency is 3 cycles.
- Back-to-back drains give one `sasa_wen` per cycle with no bubbles.
- The last write is at edge Ew. SETTLE runs for `SETTLE_CYCLES` cycles, then IDLE, then `sasa_enable` restores. The earliest re-enable is edge Ew + `SETTLE_CYCLES` + 2.
- `sasa_wen` is high for exactly one cycle per popped entry.

## Configuration
- `SPARCE_LOADER_STATUS_EN`, when defined, adds `commit_count`, out, 16 bits.
  - It increments on every cycle where `sasa_wen` is 1, wraps from 0xFFFF to 0, and resets to 0.
- When undefined, the port and its counter are absent and all other behaviour is identical.

## Test plan
- Single write, with `enable_req` = 1 and `skipping` = 0: push addr 0x4, data 0x1234_5678.
  - `sasa_enable` drops at E1.
  - `sasa_wen` pulses once after E3 with 0x4 / 0x1234_5678.
  - `sasa_enable` returns to 1 at E3 + `SETTLE_CYCLES` + 2.
- Fill the queue (4 pushes) while `skipping` = 1.
  - `req_ready` = 0 after the 4th push and a 5th `req_valid` is not accepted.
  - State holds in QUIESCE with no `sasa_wen`.
  - Releasing `skipping` gives 4 consecutive `sasa_wen` pulses in FIFO order.
- Push during SETTLE, on its first cycle: the state returns to DRAIN, `sasa_enable` stays 0 throughout, and the second write issues.
- Assert `nRST` mid-DRAIN with 2 entries queued.
  - All outputs go to 0 immediately; after release, no further `sasa_wen` appears and `req_ready` = 1.
- `enable_req` toggles 1→0 during DRAIN: after the return to IDLE, `sasa_enable` = 0.
- With `SPARCE_LOADER_STATUS_EN`: preload the count near wrap, at 0xFFFE, then issue 3 writes; `commit_count` reads 0x0001.

Source files
------------

// File: rtl/sparce_sasa_loader.sv
// sparce_sasa_loader: write-sequencing controller for the SparCE SASA table.
// Buffers CSR write requests in a small circular queue. It takes the table out of
// service (sasa_enable low) and waits for any in-flight skip to finish. It then
// drains the queue one write per cycle and holds lookups off for a settle window.
// Optional feature macro: SPARCE_LOADER_STATUS_EN adds a 16-bit commit_count output.
module sparce_sasa_loader #(
    parameter int unsigned QUEUE_DEPTH   = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic        enable_req,
    input  logic        skipping,
    output logic        sasa_wen,
    output logic [31:0] sasa_addr,
    output logic [31:0] sasa_data,
    output logic        sasa_enable,
`ifdef SPARCE_LOADER_STATUS_EN
    output logic [15:0] commit_count,
`endif
    output logic        busy
);

    localparam int unsigned AW = $clog2(QUEUE_DEPTH);
    localparam int unsigned PW = AW + 1;
    // Wide enough to hold SETTLE_CYCLES-1, never zero-width
    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StQuiesce, StDrain, StSettle} state_e;

    state_e          state_q;
    logic [CW-1:0]   settle_cnt_q;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [63:0]     mem_q [QUEUE_DEPTH];
    logic            sasa_wen_q;
    logic [31:0]     sasa_addr_q;
    logic [31:0]     sasa_data_q;
    logic            sasa_enable_q;
    logic            full, empty, push, pop;
    logic [63:0]     head;

    // Pointer MSBs differ only when the write pointer has lapped the read pointer
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign req_ready = !full;
    assign push  = req_valid && !full;
    assign pop   = (state_q == StDrain) && !empty && !skipping;
    assign head  = mem_q[rptr_q[AW-1:0]];

    assign sasa_wen    = sasa_wen_q;
    assign sasa_addr   = sasa_addr_q;
    assign sasa_data   = sasa_data_q;
    assign sasa_enable = sasa_enable_q;
    assign busy        = (state_q != StIdle);

    // Next-state pointer arithmetic for push/pop
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = wptr_q + PW'(1);
        if (pop)  rptr_d = rptr_q + PW'(1);
    end

    // Queue pointers; reset discards any queued writes
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Queue storage; contents are only meaningful between the pointers
    always_ff @(posedge CLK) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= {req_addr, req_data};
    end

    // Sequencing FSM with registered table-side outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= StIdle;
            settle_cnt_q  <= '0;
            sasa_wen_q    <= 1'b0;
            sasa_addr_q   <= '0;
            sasa_data_q   <= '0;
            sasa_enable_q <= 1'b0;
        end else begin
            sasa_wen_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        state_q       <= StQuiesce;
                        sasa_enable_q <= 1'b0;
                    end else begin
                        sasa_enable_q <= enable_req;
                    end
                end
                StQuiesce: begin
                    sasa_enable_q <= 1'b0;
                    if (!skipping) state_q <= StDrain;
                end
                StDrain: begin
                    sasa_enable_q <= 1'b0;
                    // A skip here is abnormal; stall rather than drop the entry
                    if (pop) begin
                        sasa_wen_q  <= 1'b1;
                        sasa_addr_q <= head[63:32];
                        sasa_data_q <= head[31:0];
                    end
                    if (empty) begin
                        state_q      <= StSettle;
                        settle_cnt_q <= CW'(SETTLE_CYCLES - 1);
                    end
                end
                StSettle: begin
                    sasa_enable_q <= 1'b0;
                    if (settle_cnt_q != '0) settle_cnt_q <= settle_cnt_q - CW'(1);
                    if (!empty) begin
                        state_q <= StDrain;
                    end else if (settle_cnt_q == '0) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef SPARCE_LOADER_STATUS_EN
    logic [15:0] commit_count_q;

    // Count committed table writes, wrapping at 16 bits
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) commit_count_q <= '0;
        else if (sasa_wen_q) commit_count_q <= commit_count_q + 16'd1;
    end

    assign commit_count = commit_count_q;
`endif

endmodule

// File: tb/tb_sparce_sasa_loader.sv
// Self-checking bench for sparce_sasa_loader: scoreboard of accepted writes,
// directed timing scenarios and a randomized phase.
module tb_sparce_sasa_loader;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SETTLE = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_data;
    logic        enable_req, skipping;
    logic        sasa_wen, sasa_enable, busy;
    logic [31:0] sasa_addr, sasa_data;
`ifdef SPARCE_LOADER_STATUS_EN
    logic [15:0] commit_count;
`endif

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    logic [63:0] exp_q[$];

    sparce_sasa_loader #(.QUEUE_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .enable_req  (enable_req),
        .skipping    (skipping),
        .sasa_wen    (sasa_wen),
        .sasa_addr   (sasa_addr),
        .sasa_data   (sasa_data),
        .sasa_enable (sasa_enable),
`ifdef SPARCE_LOADER_STATUS_EN
        .commit_count(commit_count),
`endif
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: writes must appear in acceptance order
    always @(negedge CLK) begin
        if (nRST) begin
            if (sasa_wen) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wen", 64'(sasa_wen), 64'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("write_addr", 64'(sasa_addr), 64'(e[63:32]));
                    chk("write_data", 64'(sasa_data), 64'(e[31:0]));
                end
                chk("enable_during_write", 64'(sasa_enable), 64'd0);
                model_cnt++;
            end
            if (sasa_enable) chk("enable_while_busy", 64'(busy), 64'd0);
            if (req_valid && req_ready) exp_q.push_back({req_addr, req_data});
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic wait_wen(input int bound);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!sasa_wen && n < bound);
        chk("wait_wen_timeout", 64'(sasa_wen), 64'd1);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (busy && n < bound);
        chk("wait_idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        nRST = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        req_data = '0;
        enable_req = 1'b0;
        skipping = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        // Reset state
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_wen", 64'(sasa_wen), 64'd0);
        chk("rst_enable", 64'(sasa_enable), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_addr_data", {sasa_addr, sasa_data}, 64'd0);
        nRST = 1'b1;

        // Single write: enable drops at E1, write after E3, re-enable at E3+SETTLE+2
        enable_req = 1'b1;
        repeat (3) cyc();
        chk("idle_enable_follows", 64'(sasa_enable), 64'd1);
        push(32'h4, 32'h1234_5678);
        for (int k = 0; k <= 12; k++) begin
            @(negedge CLK);
            chk($sformatf("single_enable_k%0d", k), 64'(sasa_enable),
                64'((k < 1) || (k >= 3 + int'(SETTLE) + 2)));
            chk($sformatf("single_wen_k%0d", k), 64'(sasa_wen), 64'(k == 3));
            chk($sformatf("single_busy_k%0d", k), 64'(busy),
                64'((k >= 1) && (k < 3 + int'(SETTLE) + 1)));
        end

        // Fill queue while skipping; a fifth request must be refused
        skipping = 1'b1;
        cyc();
        for (int i = 0; i < int'(DEPTH); i++) push($urandom, $urandom);
        chk("full_ready", 64'(req_ready), 64'd0);
        req_valid = 1'b1;
        req_addr = 32'hdead_beef;
        req_data = 32'hbad0_bad0;
        repeat (4) begin
            @(negedge CLK);
            chk("quiesce_hold_busy", 64'(busy), 64'd1);
            chk("quiesce_no_wen", 64'(sasa_wen), 64'd0);
        end
        cyc();
        req_valid = 1'b0;
        skipping = 1'b0;
        begin
            int first = -1, last = -1, cnt = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge CLK);
                if (sasa_wen) begin
                    if (first < 0) first = k;
                    last = k;
                    cnt++;
                end
            end
            chk("burst_count", 64'(cnt), 64'(DEPTH));
            chk("burst_no_bubbles", 64'(last - first), 64'(DEPTH - 1));
        end
        wait_idle(20);

        // Push landing on the first SETTLE cycle sends the block back to DRAIN
        push($urandom, $urandom);
        wait_wen(10);
        @(posedge CLK);
        #1;
        push($urandom, $urandom);
        begin
            int n = 0;
            do begin
                @(negedge CLK);
                n++;
                chk("settle_enable_low", 64'(sasa_enable), 64'd0);
            end while (!sasa_wen && n < 20);
            chk("settle_second_write", 64'(sasa_wen), 64'd1);
        end
        wait_idle(20);

        // enable_req changes during DRAIN only take effect back in IDLE
        enable_req = 1'b1;
        repeat (2) cyc();
        push($urandom, $urandom);
        push($urandom, $urandom);
        wait_wen(10);
        enable_req = 1'b0;
        wait_idle(20);
        repeat (2) cyc();
        chk("enable_after_toggle", 64'(sasa_enable), 64'd0);

        // Randomized phase
        for (int c = 0; c < 400; c++) begin
            req_valid  = ($urandom_range(0, 1) == 1);
            req_addr   = $urandom;
            req_data   = $urandom;
            skipping   = ($urandom_range(0, 7) == 0);
            enable_req = ($urandom_range(0, 1) == 1);
            cyc();
        end
        req_valid = 1'b0;
        skipping  = 1'b0;
        wait_idle(50);
        chk("random_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-DRAIN with two entries still queued
        skipping = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) push($urandom, $urandom);
        skipping = 1'b0;
        wait_wen(10);
        #1;
        nRST = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #1;
        chk("midrst_wen", 64'(sasa_wen), 64'd0);
        chk("midrst_enable", 64'(sasa_enable), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_addr_data", {sasa_addr, sasa_data}, 64'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk("post_rst_no_wen", 64'(sasa_wen), 64'd0);
        end
        chk("post_rst_ready", 64'(req_ready), 64'd1);

        // Activity after reset still works
        push(32'h40, 32'hcafe_f00d);
        wait_wen(10);
        wait_idle(20);
        chk("final_drained", 64'(exp_q.size()), 64'd0);
`ifdef SPARCE_LOADER_STATUS_EN
        chk("commit_count", 64'(commit_count), 64'(model_cnt[15:0]));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
